// File: rtl/muldiv_pkg.sv
// Shared types for the iterative MUL/DIV/REM sequencer (funct7=0000001 R-type ops).
// Pure declarations: no latency, no backpressure.
package muldiv_pkg;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM, OP_RSVD} md_op_t;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} md_state_t;
    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;
endpackage

// File: rtl/muldiv_seq_if.sv
// Controller <-> muldiv_seq request/result bundle; the controller is master.
// No storage; stall is the only backpressure and flows back to the controller.
interface muldiv_seq_if #(parameter int WIDTH = 32);
    import muldiv_pkg::*;

    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, b, input busy, stall, done, result);
    modport slave  (input start, op, a, b, output busy, stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/DIV/REM: done WIDTH+1 cycles after start (1 cycle for div-by-zero, op=11,
// and MUL when MULDIV_FAST_MUL_EN is defined); core is held via stall, starts outside IDLE ignored.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  md
);

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    md_op_t           r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;     // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0] r_mplr;    // MUL multiplier / DIV quotient (seeded with dividend)
    logic [WIDTH-1:0] r_mcand;   // MUL multiplicand / DIV divisor
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_last;
    logic             w_exc;
    logic [WIDTH-1:0] w_exc_result;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_q;

    assign w_accept = (r_state == S_IDLE) && md.start;
    assign w_last   = (r_cnt == CNT_W'(1));

    // Operations that finish without iterating, and the value they return.
    always_comb begin
        w_exc        = 1'b0;
        w_exc_result = '0;
        case (md.op)
            OP_DIV: begin
                w_exc        = (md.b == '0);
                w_exc_result = '1;
            end
            OP_REM: begin
                w_exc        = (md.b == '0);
                w_exc_result = md.a;
            end
            OP_RSVD: begin
                w_exc        = 1'b1;
                w_exc_result = '0;
            end
            default: begin
`ifdef MULDIV_FAST_MUL_EN
                w_exc        = 1'b1;
                w_exc_result = md.a * md.b;
`else
                w_exc        = 1'b0;
                w_exc_result = '0;
`endif
            end
        endcase
    end

    assign w_mul_acc  = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    // Remainder widened by one bit so the shifted-out MSB takes part in the compare.
    assign w_rem_sh   = {r_acc, r_mplr[WIDTH-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_mcand};
    assign w_ge       = ~w_rem_diff[WIDTH];
    assign w_div_rem  = w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_q    = {r_mplr[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (md.start) w_state_nxt = w_exc ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mplr   <= '0;
            r_mcand  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= md.op;
            r_cnt   <= CNT_W'(WIDTH);
            r_acc   <= '0;
            r_mplr  <= (md.op == OP_MUL) ? md.b : md.a;
            r_mcand <= (md.op == OP_MUL) ? md.a : md.b;
            if (w_exc) r_result <= w_exc_result;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_op == OP_MUL) begin
                r_acc   <= w_mul_acc;
                r_mplr  <= r_mplr >> 1;
                r_mcand <= r_mcand << 1;
            end else begin
                r_acc  <= w_div_rem;
                r_mplr <= w_div_q;
            end
            if (w_last) begin
                case (r_op)
                    OP_MUL:  r_result <= w_mul_acc;
                    OP_DIV:  r_result <= w_div_q;
                    default: r_result <= w_div_rem;
                endcase
            end
        end
    end

    assign md.busy   = (r_state == S_CALC);
    assign md.done   = (r_state == S_DONE);
    assign md.stall  = w_accept || (r_state == S_CALC);
    assign md.result = r_result;

endmodule
